// File: rtl/msg_loader_if.sv
// Byte-stream handshake into msg_loader: valid/data/last from the source, ready back from the loader.
interface msg_loader_if #(
    parameter int unsigned SYMBOL_WIDTH = 8
);
    logic                    in_valid;
    logic [SYMBOL_WIDTH-1:0] in_data;
    logic                    in_last;
    logic                    regop_in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  regop_in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output regop_in_ready
    );
endinterface

// File: rtl/msg_loader.sv
// Writes an incoming byte stream into the message SRAM, then hands the SRAM to gen_padded with a
// go pulse and the message length, holding off new input until gen_padded reports completion.
module msg_loader #(
    parameter int unsigned MAX_MESSAGE_LENGTH = 55,
    parameter int unsigned SYMBOL_WIDTH       = 8,
    parameter int unsigned ADDR_WIDTH         = $clog2(MAX_MESSAGE_LENGTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    msg_loader_if.slave             in_if,
    input  logic                    pad_rdy,
    output logic                    regop_msg_mem_en,
    output logic                    regop_msg_mem_write,
    output logic [ADDR_WIDTH-1:0]   regop_msg_mem_addr,
    output logic [SYMBOL_WIDTH-1:0] regop_msg_mem_wdata,
    output logic                    regop_mem_own,
    output logic                    regop_main_go,
    output logic [ADDR_WIDTH-1:0]   regop_msg_len,
    output logic                    regop_overflow
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLoad  = 3'd1;
    localparam logic [2:0] StDrain = 3'd2;
    localparam logic [2:0] StGo    = 3'd3;
    localparam logic [2:0] StWait  = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] MaxLen = ADDR_WIDTH'(MAX_MESSAGE_LENGTH);
    localparam logic [ADDR_WIDTH-1:0] One    = ADDR_WIDTH'(1);

    logic [2:0]              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   count_q, count_d;
    logic                    in_ready_q, in_ready_d;
    logic                    mem_en_q, mem_en_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [SYMBOL_WIDTH-1:0] wdata_q, wdata_d;
    logic                    mem_own_q, mem_own_d;
    logic                    main_go_q, main_go_d;
    logic [ADDR_WIDTH-1:0]   msg_len_q, msg_len_d;
    logic                    overflow_q, overflow_d;
    logic                    accept;

    assign accept = in_if.in_valid & in_ready_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        in_ready_d = in_ready_q;
        mem_en_d   = 1'b0;
        write_d    = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        mem_own_d  = mem_own_q;
        main_go_d  = 1'b0;
        msg_len_d  = msg_len_q;
        overflow_d = overflow_q;

        case (state_q)
            StIdle: begin
                in_ready_d = 1'b1;
                mem_own_d  = 1'b1;
                if (accept) begin
                    overflow_d = 1'b0;
                    mem_en_d   = 1'b1;
                    write_d    = 1'b1;
                    addr_d     = '0;
                    wdata_d    = in_if.in_data;
                    count_d    = One;
                    if (in_if.in_last) begin
                        msg_len_d  = One;
                        in_ready_d = 1'b0;
                        state_d    = StGo;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                if (accept) begin
                    if (count_q < MaxLen) begin
                        mem_en_d = 1'b1;
                        write_d  = 1'b1;
                        addr_d   = count_q;
                        wdata_d  = in_if.in_data;
                        count_d  = count_q + One;
                        if (in_if.in_last) begin
                            msg_len_d  = count_q + One;
                            in_ready_d = 1'b0;
                            state_d    = StGo;
                        end
                    end else begin
                        // SRAM is full: drop the byte and swallow the rest of the message.
                        overflow_d = 1'b1;
                        state_d    = in_if.in_last ? StIdle : StDrain;
                    end
                end
            end
            StDrain: begin
                in_ready_d = 1'b1;
                if (accept && in_if.in_last) begin
                    state_d = StIdle;
                end
            end
            StGo: begin
                // Final write already issued last cycle, so the SRAM can be released now.
                in_ready_d = 1'b0;
                mem_own_d  = 1'b0;
                main_go_d  = 1'b1;
                state_d    = StWait;
            end
            StWait: begin
                in_ready_d = 1'b0;
                mem_own_d  = 1'b0;
                if (pad_rdy) begin
                    in_ready_d = 1'b1;
                    mem_own_d  = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            mem_en_q   <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_own_q  <= 1'b1;
            main_go_q  <= 1'b0;
            msg_len_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            mem_en_q   <= mem_en_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mem_own_q  <= mem_own_d;
            main_go_q  <= main_go_d;
            msg_len_q  <= msg_len_d;
            overflow_q <= overflow_d;
        end
    end

    assign in_if.regop_in_ready = in_ready_q;
    assign regop_msg_mem_en     = mem_en_q;
    assign regop_msg_mem_write  = write_q;
    assign regop_msg_mem_addr   = addr_q;
    assign regop_msg_mem_wdata  = wdata_q;
    assign regop_mem_own        = mem_own_q;
    assign regop_main_go        = main_go_q;
    assign regop_msg_len        = msg_len_q;
    assign regop_overflow       = overflow_q;

endmodule

// File: tb/tb_msg_loader.sv
// Directed and randomized message streams checked against a length-based model of the loader.
module tb_msg_loader;

    localparam int MAXL = 55;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       pad_rdy = 1'b0;
    logic       mem_en, mem_write, mem_own, main_go, overflow;
    logic [5:0] mem_addr, msg_len;
    logic [7:0] mem_wdata;

    msg_loader_if #(.SYMBOL_WIDTH(8)) bus ();

    msg_loader dut (
        .clock               (clock),
        .reset               (reset),
        .in_if               (bus),
        .pad_rdy             (pad_rdy),
        .regop_msg_mem_en    (mem_en),
        .regop_msg_mem_write (mem_write),
        .regop_msg_mem_addr  (mem_addr),
        .regop_msg_mem_wdata (mem_wdata),
        .regop_mem_own       (mem_own),
        .regop_main_go       (main_go),
        .regop_msg_len       (msg_len),
        .regop_overflow      (overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         cyc;
        logic       ovf;
        logic       own;
        logic [5:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        wq[$];
    int         go_cyc[$];
    logic [5:0] go_len[$];
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] msg [0:63];
    int         last_good = 0;

    always @(posedge clock) cyc++;

    // Passive monitor: log every SRAM write and go pulse as seen between edges.
    always @(negedge clock) begin
        if (mem_en && mem_write) wq.push_back('{cyc, overflow, mem_own, mem_addr, mem_wdata});
        if (main_go) begin
            go_cyc.push_back(cyc);
            go_len.push_back(msg_len);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int len, input int mode);
        for (int k = 0; k < len; k++) msg[k] = (mode == 0) ? 8'($urandom) : 8'(k);
    endtask

    task automatic clear_logs();
        wq.delete();
        go_cyc.delete();
        go_len.delete();
    endtask

    // Drive one message; bytes advance only when in_ready is seen high before the sampling edge.
    task automatic send(input int len, input int gap_pct);
        int i = 0;
        int guard = 0;
        while (i < len && guard < 3000) begin
            @(negedge clock);
            guard++;
            pad_rdy = 1'($urandom);
            if (int'($urandom_range(99)) < gap_pct) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                bus.in_last  = 1'($urandom);
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = msg[i];
                bus.in_last  = (i == len - 1);
                if (bus.regop_in_ready) i++;
            end
        end
        @(negedge clock);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        pad_rdy      = 1'b0;
        check("send_timeout", guard, (guard < 3000) ? guard : 0);
    endtask

    task automatic check_msg(input int len, input bit hold_valid);
        int n = (len > MAXL) ? MAXL : len;
        repeat (4) @(negedge clock);
        check("wr_count", wq.size(), n);
        for (int k = 0; k < n && k < wq.size(); k++) begin
            check($sformatf("wr_addr[%0d]", k), wq[k].addr, k);
            check($sformatf("wr_data[%0d]", k), wq[k].data, msg[k]);
            check($sformatf("wr_own[%0d]", k), wq[k].own, 1);
            check($sformatf("wr_ovf[%0d]", k), wq[k].ovf, 0);
            if (k > 0) check($sformatf("wr_b2b[%0d]", k), wq[k].cyc - wq[k-1].cyc >= 1, 1);
        end
        if (len <= MAXL) begin
            check("go_count", go_cyc.size(), 1);
            if (go_cyc.size() > 0 && wq.size() > 0) begin
                check("go_len", go_len[0], len);
                check("go_latency", go_cyc[0] - wq[wq.size()-1].cyc, 1);
            end
            check("msg_len", msg_len, len);
            check("overflow", overflow, 0);
            check("wait_ready", bus.regop_in_ready, 0);
            check("wait_own", mem_own, 0);
            for (int w = 0; w < 3; w++) begin
                bus.in_valid = hold_valid;
                bus.in_data  = 8'($urandom);
                bus.in_last  = 1'($urandom);
                @(negedge clock);
            end
            check("wait_no_write", wq.size(), n);
            pad_rdy = 1'b1;
            @(negedge clock);
            pad_rdy      = 1'b0;
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
            check("idle_ready", bus.regop_in_ready, 1);
            check("idle_own", mem_own, 1);
            @(negedge clock);
            check("post_wait_writes", wq.size(), n);
            check("post_wait_go", go_cyc.size(), 1);
            last_good = len;
        end else begin
            check("ovf_go_count", go_cyc.size(), 0);
            check("ovf_flag", overflow, 1);
            check("ovf_ready", bus.regop_in_ready, 1);
            check("ovf_own", mem_own, 1);
            check("ovf_msg_len", msg_len, last_good);
        end
        clear_logs();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, bus.regop_in_ready, 0);
        check({tag, "_en"}, mem_en, 0);
        check({tag, "_write"}, mem_write, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_own"}, mem_own, 1);
        check({tag, "_go"}, main_go, 0);
        check({tag, "_len"}, msg_len, 0);
        check({tag, "_ovf"}, overflow, 0);
    endtask

    initial begin
        int i;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_vals("rst");
        reset = 1'b1;
        @(negedge clock);
        check("ready_after_reset", bus.regop_in_ready, 1);
        clear_logs();

        // "abcdefg" back to back, valid held during WAIT_DONE
        for (int k = 0; k < 7; k++) msg[k] = 8'h61 + 8'(k);
        send(7, 0);
        check_msg(7, 1'b1);

        msg[0] = 8'h41;
        send(1, 0);
        check_msg(1, 1'b0);

        fill(55, 1);
        send(55, 0);
        check_msg(55, 1'b1);

        fill(57, 0);
        send(57, 0);
        check_msg(57, 1'b0);

        fill(3, 0);
        send(3, 0);
        check_msg(3, 1'b0);

        // gapped input with valid held high while waiting for pad_rdy
        fill(3, 0);
        send(3, 60);
        check_msg(3, 1'b1);

        for (int r = 0; r < 5; r++) begin
            int len = int'($urandom_range(1, 60));
            fill(len, 0);
            send(len, int'($urandom_range(0, 50)));
            check_msg(len, 1'($urandom));
        end

        // reset after 4 bytes of an 8-byte message
        fill(8, 0);
        i = 0;
        while (i < 4) begin
            @(negedge clock);
            bus.in_valid = 1'b1;
            bus.in_data  = msg[i];
            bus.in_last  = 1'b0;
            if (bus.regop_in_ready) i++;
        end
        @(negedge clock);
        bus.in_valid = 1'b0;
        #1 reset = 1'b0;
        #1 check_reset_vals("async_rst");
        repeat (3) @(negedge clock);
        check("rst_partial_writes", wq.size(), 4);
        check("rst_no_go", go_cyc.size(), 0);
        reset = 1'b1;
        @(negedge clock);
        clear_logs();
        last_good = 0;
        fill(2, 0);
        send(2, 0);
        check_msg(2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
